// File: rtl/pgm_sched_rd_pkg.sv
// Shared constants, state encoding and helpers for the packet scheduler read path.
package pgm_sched_rd_pkg;

    localparam int unsigned NUM_STREAMS       = 4;
    localparam int unsigned DEF_MAX_PKT_WORDS = 128;
    localparam int unsigned SLOT_SHIFT        = 7;    // each stream slot spans 128 cache words
    localparam int unsigned ADDR_W            = 10;
    localparam int unsigned DATA_W            = 134;
    localparam int unsigned ENTRY_W           = 138;

    // Table entry field layout: {start_time, rate, base_addr}
    localparam int unsigned START_MSB = 137;
    localparam int unsigned START_LSB = 74;
    localparam int unsigned RATE_MSB  = 73;
    localparam int unsigned RATE_LSB  = 10;
    localparam int unsigned BASE_MSB  = 9;
    localparam int unsigned BASE_LSB  = 0;
    localparam int unsigned IDX_MSB   = 8;
    localparam int unsigned IDX_LSB   = 7;

    // Word type codes carried in data[133:132]
    localparam logic [1:0] WT_HEAD = 2'b01;
    localparam logic [1:0] WT_BODY = 2'b11;
    localparam logic [1:0] WT_TAIL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

    // Lowest set index wins; returns 0 for an empty vector.
    function automatic logic [1:0] pick_lowest(input logic [NUM_STREAMS-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pgm_sched_rd_if.sv
// Cache read port and packet output port of the scheduler.
interface pgm_sched_rd_if;
    import pgm_sched_rd_pkg::*;

    logic              out_pgm_wr_raddr_wr;
    logic [ADDR_W-1:0] out_pgm_wr_raddr;
    logic [DATA_W-1:0] in_pgm_wr_data;
    logic [DATA_W-1:0] out_pgm_data;
    logic              out_pgm_data_wr;
    logic              in_pgm_data_ready;

    modport master (
        output out_pgm_wr_raddr_wr,
        output out_pgm_wr_raddr,
        input  in_pgm_wr_data,
        output out_pgm_data,
        output out_pgm_data_wr,
        input  in_pgm_data_ready
    );

    modport slave (
        input  out_pgm_wr_raddr_wr,
        input  out_pgm_wr_raddr,
        output in_pgm_wr_data,
        input  out_pgm_data,
        input  out_pgm_data_wr,
        output in_pgm_data_ready
    );

endinterface

// File: rtl/pgm_sched_table.sv
// Four-entry schedule table: host writes, post-packet re-arm and eligibility vector.
module pgm_sched_table
    import pgm_sched_rd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [ENTRY_W-1:0]     wr_data,
    input  logic                   upd_en,
    input  logic [1:0]             upd_idx,
    input  logic [63:0]            global_time,
    output logic [NUM_STREAMS-1:0] eligible
);

    logic [NUM_STREAMS-1:0] valid_q, valid_d;
    logic [63:0]            next_time_q [NUM_STREAMS];
    logic [63:0]            next_time_d [NUM_STREAMS];
    logic [63:0]            rate_q      [NUM_STREAMS];
    logic [63:0]            rate_d      [NUM_STREAMS];
    logic [1:0]             wr_idx;
    logic                   unused_base;

    assign wr_idx      = wr_data[IDX_MSB:IDX_LSB];
    // Only the stream index bits of base_addr matter here.
    assign unused_base = ^{wr_data[BASE_MSB], wr_data[IDX_LSB-1:BASE_LSB]};

    // Next-state: clear beats host write, host write beats re-arm of the same entry.
    always_comb begin
        valid_d     = valid_q;
        next_time_d = next_time_q;
        rate_d      = rate_q;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (clr) begin
                valid_d[i]     = 1'b0;
                next_time_d[i] = '0;
                rate_d[i]      = '0;
            end else if (wr_en && wr_idx == 2'(i)) begin
                next_time_d[i] = wr_data[START_MSB:START_LSB];
                rate_d[i]      = wr_data[RATE_MSB:RATE_LSB];
                valid_d[i]     = |wr_data[RATE_MSB:RATE_LSB];
            end else if (upd_en && upd_idx == 2'(i)) begin
                next_time_d[i] = next_time_q[i] + rate_q[i];
            end
        end
    end

    // Table state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                next_time_q[i] <= '0;
                rate_q[i]      <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                next_time_q[i] <= next_time_d[i];
                rate_q[i]      <= rate_d[i];
            end
        end
    end

    // An entry is due once global time has reached its next send time.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            eligible[i] = valid_q[i] && (global_time >= next_time_q[i]);
        end
    end

endmodule

// File: rtl/pgm_sched_rd.sv
// Time-triggered packet scheduler: picks a due stream, streams its cached packet out.
module pgm_sched_rd
    import pgm_sched_rd_pkg::*;
#(
    parameter string       PLATFORM      = "xilinx",
    parameter int unsigned MAX_PKT_WORDS = DEF_MAX_PKT_WORDS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pgm_config_reset,
    input  logic               sent_ready,
    input  logic               table_entry_flag,
    input  logic [ENTRY_W-1:0] table_entry_data,
    input  logic [63:0]        global_time,
    pgm_sched_rd_if.master     pgm,
    output logic [31:0]        sent_pkt_cnt,
    output logic               sched_err
);

    state_e                 state_q, state_d;
    logic [1:0]             sel_q, sel_d;
    logic [ADDR_W-1:0]      offset_q, offset_d;
    logic                   rd_stop_q, rd_stop_d;
    logic                   rd_vld_q;
    logic                   cfg_seen_q, cfg_seen_d;
    logic [NUM_STREAMS-1:0] eligible;
    logic                   start_pkt, rd_en, capture, is_tail, pkt_end, forced_tail, upd_en;
    logic [DATA_W-1:0]      out_data_q;
    logic                   out_wr_q;
    logic [31:0]            cnt_q;
    logic                   err_q;
    logic                   unused_platform;

    assign unused_platform = (PLATFORM == "xilinx");

    pgm_sched_table u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (pgm_config_reset),
        .wr_en       (table_entry_flag),
        .wr_data     (table_entry_data),
        .upd_en      (upd_en),
        .upd_idx     (sel_q),
        .global_time (global_time),
        .eligible    (eligible)
    );

    assign start_pkt = sent_ready && !pgm_config_reset && pgm.in_pgm_data_ready && (|eligible);
    // rd_stop_q marks that the last permitted read has been issued.
    assign rd_en     = (state_q == S_RD) && !rd_stop_q;
    // Data returned while still in S_RD belongs to the packet; in S_FLUSH it is the overrun read.
    assign capture   = (state_q == S_RD) && rd_vld_q;
    assign is_tail   = (pgm.in_pgm_wr_data[DATA_W-1 -: 2] == WT_TAIL);
    assign pkt_end   = capture && (is_tail || rd_stop_q);
    assign forced_tail = capture && rd_stop_q && !is_tail;

    assign pgm.out_pgm_wr_raddr_wr = rd_en;
    assign pgm.out_pgm_wr_raddr    = (ADDR_W'(sel_q) << SLOT_SHIFT) + offset_q;
    assign pgm.out_pgm_data        = out_data_q;
    assign pgm.out_pgm_data_wr     = out_wr_q;
    assign sent_pkt_cnt            = cnt_q;
    assign sched_err               = err_q;

    // Next-state and table re-arm request.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        offset_d   = offset_q;
        rd_stop_d  = rd_stop_q;
        cfg_seen_d = cfg_seen_q | pgm_config_reset;
        upd_en     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_pkt) begin
                    state_d    = S_RD;
                    sel_d      = pick_lowest(eligible);
                    offset_d   = '0;
                    rd_stop_d  = 1'b0;
                    cfg_seen_d = 1'b0;
                end
            end
            S_RD: begin
                if (rd_en) begin
                    if (offset_q == ADDR_W'(MAX_PKT_WORDS - 1)) rd_stop_d = 1'b1;
                    else                                       offset_d  = offset_q + ADDR_W'(1);
                end
                if (pkt_end) state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = S_IDLE;
                // A config reset during this packet leaves the (cleared) table alone.
                upd_en  = !cfg_seen_d;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and read pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            offset_q   <= '0;
            rd_stop_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            cfg_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            offset_q   <= offset_d;
            rd_stop_q  <= rd_stop_d;
            rd_vld_q   <= rd_en;
            cfg_seen_q <= cfg_seen_d;
        end
    end

    // Output word register; a packet cut at the size limit gets a synthetic tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
        end else begin
            out_wr_q <= capture;
            if (capture) begin
                out_data_q <= forced_tail ? {WT_TAIL, pgm.in_pgm_wr_data[DATA_W-3:0]}
                                          : pgm.in_pgm_wr_data;
            end
        end
    end

    // Sent-packet counter and sticky size-overrun error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (pgm_config_reset)                       cnt_q <= '0;
            else if (state_q == S_FLUSH && !cfg_seen_q) cnt_q <= cnt_q + 32'd1;
            if (forced_tail) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pgm_sched_rd.sv
// Scoreboard bench for pgm_sched_rd: directed schedules, cache model, output monitor.
`timescale 1ns/1ps
module tb_pgm_sched_rd;
    import pgm_sched_rd_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pgm_config_reset = 1'b0;
    logic          sent_ready = 1'b0;
    logic          table_entry_flag = 1'b0;
    logic [137:0]  table_entry_data = '0;
    logic [63:0]   global_time = '0;
    logic [31:0]   sent_pkt_cnt;
    logic          sched_err;

    pgm_sched_rd_if bus ();

    pgm_sched_rd #(
        .PLATFORM      ("xilinx"),
        .MAX_PKT_WORDS (128)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pgm_config_reset (pgm_config_reset),
        .sent_ready       (sent_ready),
        .table_entry_flag (table_entry_flag),
        .table_entry_data (table_entry_data),
        .global_time      (global_time),
        .pgm              (bus),
        .sent_pkt_cnt     (sent_pkt_cnt),
        .sched_err        (sched_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) global_time <= global_time + 64'd1;

    // Packet cache model: one-cycle read latency.
    logic [133:0] mem [1024];
    always @(posedge clk) begin
        if (bus.out_pgm_wr_raddr_wr) bus.in_pgm_wr_data <= mem[bus.out_pgm_wr_raddr];
    end

    typedef struct {
        longint       t;
        logic [133:0] d;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Monitor: every emitted word must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && bus.out_pgm_data_wr) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_word t=%0d got %h required no word",
                         global_time, bus.out_pgm_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (bus.out_pgm_data !== e.d || (e.t >= 0 && longint'(global_time) != e.t)) begin
                    n_fail++;
                    $display("FAIL out_word got t=%0d data=%h required t=%0d data=%h",
                             global_time, bus.out_pgm_data, e.t, e.d);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_gt(input longint t);
        while (longint'(global_time) < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_entry(input logic [63:0] st, input logic [63:0] rt,
                               input logic [9:0] base);
        table_entry_flag = 1'b1;
        table_entry_data = {st, rt, base};
        @(posedge clk);
        #1;
        table_entry_flag = 1'b0;
    endtask

    task automatic push_words(input int addr, input int n, input longint t0, input bit force_tail);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.d = mem[addr + k];
            if (force_tail && k == n - 1) e.d[133:132] = 2'b10;
            e.t = t0 + k;
            q.push_back(e);
        end
    endtask

    task automatic wait_cnt(input string name, input logic [31:0] target, input longint limit);
        while (sent_pkt_cnt != target && longint'(global_time) < limit) begin
            @(posedge clk);
            #1;
        end
        chk(name, 64'(sent_pkt_cnt), 64'(target));
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin
        // Garbage heads everywhere so that any stray read shows up as a wrong word.
        for (int i = 0; i < 1024; i++) mem[i] = {2'b01, 132'h5A5A_0000 + 132'(i)};
        mem[0]   = {2'b01, 132'hA0};
        mem[1]   = {2'b11, 132'hA1};
        mem[2]   = {2'b10, 132'hA2};
        mem[128] = {2'b01, 132'hB0};
        mem[129] = {2'b10, 132'hB1};
        mem[256] = {2'b01, 132'hC0};
        mem[257] = {2'b11, 132'hC1};
        mem[258] = {2'b11, 132'hC2};
        mem[259] = {2'b10, 132'hC3};
        for (int k = 0; k < 128; k++) mem[384 + k] = {(k == 0) ? 2'b01 : 2'b11, 132'hD000 + 132'(k)};

        bus.in_pgm_data_ready = 1'b1;
        sent_ready            = 1'b1;

        @(posedge clk);
        #1;
        chk("rst_raddr_wr", 64'(bus.out_pgm_wr_raddr_wr), 64'd0);
        chk("rst_raddr",    64'(bus.out_pgm_wr_raddr),    64'd0);
        chk("rst_data",     64'(bus.out_pgm_data[63:0]),  64'd0);
        chk("rst_data_wr",  64'(bus.out_pgm_data_wr),     64'd0);
        chk("rst_cnt",      64'(sent_pkt_cnt),            64'd0);
        chk("rst_err",      64'(sched_err),               64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Periodic stream 0, plus a rate-0 stream 3 that must never send.
        write_entry(64'd0, 64'd0, 10'd384);
        write_entry(64'd100, 64'd50, 10'd0);
        push_words(0, 3, 103, 1'b0);
        push_words(0, 3, 153, 1'b0);
        push_words(0, 3, 203, 1'b0);
        wait_cnt("cnt_after_3_periodic", 32'd3, 300);
        chk("q_empty_periodic", 64'(q.size()), 64'd0);
        chk("err_clean", 64'(sched_err), 64'd0);
        write_entry(64'd0, 64'd0, 10'd0);

        // Two streams due together: lower index first, then the other.
        write_entry(64'd500, 64'd1000, 10'd128);
        write_entry(64'd500, 64'd1000, 10'd256);
        push_words(128, 2, 503, 1'b0);
        push_words(256, 4, 508, 1'b0);
        wait_cnt("cnt_after_pair", 32'd5, 700);
        write_entry(64'd0, 64'd0, 10'd128);
        write_entry(64'd0, 64'd0, 10'd256);

        // Tail-less packet: cut at 128 words with a forced tail.
        write_entry(64'd700, 64'd100000, 10'd384);
        push_words(384, 128, 703, 1'b1);
        wait_cnt("cnt_after_forced", 32'd6, 1000);
        chk("err_forced_tail", 64'(sched_err), 64'd1);
        write_entry(64'd0, 64'd0, 10'd384);

        // Downstream not ready when due; released 20 cycles later, dropped mid-packet.
        write_entry(64'd1000, 64'd100000, 10'd0);
        wait_gt(950);
        bus.in_pgm_data_ready = 1'b0;
        wait_gt(1020);
        bus.in_pgm_data_ready = 1'b1;
        push_words(0, 3, 1023, 1'b0);
        wait_gt(1022);
        bus.in_pgm_data_ready = 1'b0;
        wait_cnt("cnt_after_ready", 32'd7, 1100);
        bus.in_pgm_data_ready = 1'b1;

        // Config reset mid-packet: packet completes, counter cleared, nothing further.
        write_entry(64'd1200, 64'd20, 10'd256);
        push_words(256, 4, 1203, 1'b0);
        wait_gt(1204);
        pgm_config_reset = 1'b1;
        @(posedge clk);
        #1;
        pgm_config_reset = 1'b0;
        chk("cnt_cleared", 64'(sent_pkt_cnt), 64'd0);
        wait_gt(1300);
        chk("cnt_after_cfg_pkt", 64'(sent_pkt_cnt), 64'd0);
        chk("q_empty_cfg", 64'(q.size()), 64'd0);
        chk("err_survives_cfg", 64'(sched_err), 64'd1);

        // Reset mid-packet: outputs drop at once, no tail.
        write_entry(64'd1400, 64'd50000, 10'd384);
        push_words(384, 7, 1403, 1'b0);
        wait_gt(1410);
        rst_n = 1'b0;
        #1;
        chk("midrst_data_wr",  64'(bus.out_pgm_data_wr),     64'd0);
        chk("midrst_raddr_wr", 64'(bus.out_pgm_wr_raddr_wr), 64'd0);
        chk("midrst_raddr",    64'(bus.out_pgm_wr_raddr),    64'd0);
        chk("midrst_data",     64'(bus.out_pgm_data[63:0]),  64'd0);
        chk("midrst_cnt",      64'(sent_pkt_cnt),            64'd0);
        chk("midrst_err",      64'(sched_err),               64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_gt(1500);
        chk("q_empty_end", 64'(q.size()), 64'd0);
        chk("cnt_end", 64'(sent_pkt_cnt), 64'd0);

        summary();
        $finish;
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL watchdog t=%0d got timeout required completion", global_time);
        summary();
        $fatal(1, "watchdog");
    end

endmodule
